dx_pipe_latch: RTL

//  Decode/Execute pipeline register for the 5-stage core. Captures F/D decoded fields and register-file operands.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/dx_pipe_latch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, bubble word and D/X action encoding
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INSN = 32'h0;

  typedef enum logic [1:0] {
    ADVANCE = 2'd0,
    HOLD    = 2'd1,
    BUBBLE  = 2'd2,
    FLUSH   = 2'd3
  } dx_action_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dx_pipe_latch.sv
// rtl/dx_pipe_latch.sv - D/X pipeline register with stall/flush control and hazard counters
module dx_pipe_latch #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int CNT_W = 16,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(pipe_pkg::NOP_INSN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_fd,
  input  logic              stall_dx,
  input  logic              flush,
  input  logic [DATA_W-1:0] fd_insn,
  input  logic [DATA_W-1:0] fd_pc,
  input  logic [REG_W-1:0]  fd_rd,
  input  logic [REG_W-1:0]  fd_rs1,
  input  logic [REG_W-1:0]  fd_rs2,
  input  logic              fd_ld,
  input  logic              fd_st,
  input  logic              fd_valid,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] dx_insn,
  output logic [DATA_W-1:0] dx_pc,
  output logic [DATA_W-1:0] dx_a,
  output logic [DATA_W-1:0] dx_b,
  output logic [REG_W-1:0]  dx_rd,
  output logic [REG_W-1:0]  dx_rs1,
  output logic [REG_W-1:0]  dx_rs2,
  output logic              dx_ld,
  output logic              dx_st,
  output logic              dx_valid,
  output logic              pc_en,
  output logic              fd_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import pipe_pkg::*;

  dx_action_t action;
  logic       wb_live;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;

  always_comb begin
    action = ADVANCE;
    if (flush) begin
      action = FLUSH;
    end else if (stall_dx) begin
      action = HOLD;
    end else if (stall_fd) begin
      action = BUBBLE;
    end
  end

  // A taken branch redirects fetch even while a load-use stall is pending.
  assign pc_en = ~(stall_fd | stall_dx) | flush;
  assign fd_en = pc_en;

  // Register 0 is hardwired, so a writeback to it is never bypassed.
  assign wb_live = wb_we && (wb_rd != '0);
  assign cap_a = (wb_live && (wb_rd == fd_rs1)) ? wb_data : rf_a;
  assign cap_b = (wb_live && (wb_rd == fd_rs2)) ? wb_data : rf_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dx_insn  <= NOP_INSN;
      dx_pc    <= '0;
      dx_a     <= '0;
      dx_b     <= '0;
      dx_rd    <= '0;
      dx_rs1   <= '0;
      dx_rs2   <= '0;
      dx_ld    <= 1'b0;
      dx_st    <= 1'b0;
      dx_valid <= 1'b0;
    end else begin
      case (action)
        ADVANCE: begin
          dx_insn  <= fd_insn;
          dx_pc    <= fd_pc;
          dx_a     <= cap_a;
          dx_b     <= cap_b;
          dx_rd    <= fd_rd;
          dx_rs1   <= fd_rs1;
          dx_rs2   <= fd_rs2;
          dx_ld    <= fd_ld & fd_valid;
          dx_st    <= fd_st & fd_valid;
          dx_valid <= fd_valid;
        end
        HOLD: begin
          // Held operands track the load writing back underneath them.
          if (wb_live && (wb_rd == dx_rs1)) dx_a <= wb_data;
          if (wb_live && (wb_rd == dx_rs2)) dx_b <= wb_data;
        end
        default: begin
          dx_insn  <= NOP_INSN;
          dx_pc    <= '0;
          dx_a     <= '0;
          dx_b     <= '0;
          dx_rd    <= '0;
          dx_rs1   <= '0;
          dx_rs2   <= '0;
          dx_ld    <= 1'b0;
          dx_st    <= 1'b0;
          dx_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   ((action == HOLD) || (action == BUBBLE)),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (action == FLUSH),
    .count (flush_cnt)
  );

endmodule
